vga_frame_ctrl: RTL and testbench

Controller sitting between the button/LED board logic and the VGA pixel pipeline (test-pattern generator -> pixel FIFO -> VGA transmitter).
- Debounces the pattern-select button.
- Applies pattern changes only at frame boundaries.
- Primes and throttles the generator from FIFO fill status.
- Detects FIFO underflow and re-synchronises the pipeline to the next frame.

---
 rtl/vga_frame_ctrl_pkg.sv | 35 +++
 rtl/vga_frame_ctrl_btn_debounce.sv | 59 +++++
 rtl/vga_frame_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_vga_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vga_frame_ctrl_pkg
// Shared definitions for the VGA frame controller:
//   - state_t      : controller state codes (WAIT_VS=0, PRIME=1, RUN=2)
//   - ST_NOT_EMPTY : fifo_status bit meaning "FIFO holds at least one pixel"
//   - ST_HIGH      : fifo_status bit meaning "FIFO at or above 3/4 full"
//   - DEB_CYC_DEFAULT : default debounce length (10 ms at 65 MHz)
//   - next_pattern : pattern index increment with wrap at the last pattern
// ---------------------------------------------------------------------------
package vga_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    PRIME   = 2'd1,
    RUN     = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

  localparam int ST_NOT_EMPTY    = 0;
  localparam int ST_HIGH         = 3;
  localparam int DEB_CYC_DEFAULT = 650000;

  // Advance the pattern index, wrapping from the last pattern back to 0.
  function automatic logic [1:0] next_pattern(input logic [1:0] cur,
                                               input logic [1:0] last);
    logic [1:0] nxt;
    if (cur == last) begin
      nxt = 2'd0;
    end else begin
      nxt = cur + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_frame_ctrl_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronises the raw active-low button, accepts a new level only after
// DEB_CYC consecutive identical synchronised samples, and emits a one-cycle
// press event on each accepted high->low transition.
// Ports:
//   clk    in  pixel clock
//   rst    in  synchronous reset, active-high
//   btn_n  in  raw button, active-low, asynchronous to clk
//   press  out one-cycle pulse per accepted press
// ---------------------------------------------------------------------------
module btn_debounce
  import vga_frame_ctrl_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          press_r;

  // Two-flop synchroniser, stable-sample counter and press-event register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b1;
      cnt_r   <= '0;
      press_r <= 1'b0;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        // Any sample matching the current level restarts the stability run.
        cnt_r <= '0;
      end else if (cnt_r == CW'(DEB_CYC - 1)) begin
        // DEB_CYC-th differing sample in a row: accept the new level.
        level_r <= sync2_r;
        cnt_r   <= '0;
        press_r <= ~sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/vga_frame_ctrl.sv
// ---------------------------------------------------------------------------
// vga_frame_ctrl
// Frame-level controller between the button/LED board and the VGA pixel
// pipeline. Pattern changes are applied only at the VSync leading edge, the
// pattern generator is primed/throttled from FIFO fill status, and a FIFO
// underflow forces a re-sync at the next frame.
// Optional feature (macro VGA_FRAME_CTRL_AUTOCYCLE_EN): a frame counter that
// requests a pattern change every AUTO_FRAMES frames spent in PRIME/RUN.
// Ports:
//   clk          in  pixel clock
//   rst          in  synchronous reset, active-high
//   btn_n        in  raw pattern button, active-low, asynchronous
//   vs           in  VSync from transmitter, active level VS_POL
//   fifo_status  in  thermometer fill level (bit0 not empty .. bit3 >= 3/4)
//   gen_cke      out clock enable to pattern generator
//   gen_rst      out reset to pattern generator, active-high
//   fifo_flush   out empties pixel FIFO while high
//   pattern      out selected pattern index
//   underflow    out sticky underflow flag
//   state        out FSM state code
// ---------------------------------------------------------------------------
module vga_frame_ctrl
  import vga_frame_ctrl_pkg::*;
#(
  parameter int   DEB_CYC = DEB_CYC_DEFAULT,
  parameter int   N_PAT   = 4,
  parameter logic VS_POL  = 1'b0
`ifdef VGA_FRAME_CTRL_AUTOCYCLE_EN
  ,
  parameter int   AUTO_FRAMES = 120
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       vs,
  input  logic [3:0] fifo_status,
  output logic       gen_cke,
  output logic       gen_rst,
  output logic       fifo_flush,
  output logic [1:0] pattern,
  output logic       underflow,
  output logic [1:0] state
);

  localparam logic [1:0] PAT_LAST = 2'(N_PAT - 1);

  state_t     state_r;
  state_t     state_n;
  logic [1:0] pattern_r;
  logic [1:0] pattern_n;
  logic       req_r;
  logic       req_n;
  logic       underflow_r;
  logic       underflow_n;
  logic       vs_r;
  logic       vs_d_r;
  logic       vs_edge_s;
  logic       press_s;
  logic       auto_fire_s;
  logic       pattern_chg_s;

  // Only the not-empty and high-water bits steer the controller.
  logic unused_status_s;
  assign unused_status_s = ^fifo_status[2:1];

  btn_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_btn_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn_n),
    .press (press_s)
  );

  // Leading edge of the sync pulse: registered vs just became active.
  assign vs_edge_s = (vs_r == VS_POL) && (vs_d_r != VS_POL);

`ifdef VGA_FRAME_CTRL_AUTOCYCLE_EN
  localparam int FW = $clog2(AUTO_FRAMES + 1);

  logic [FW-1:0] frame_cnt_r;
  logic          counting_s;

  assign counting_s  = vs_edge_s && ((state_r == PRIME) || (state_r == RUN));
  assign auto_fire_s = counting_s && (frame_cnt_r == FW'(AUTO_FRAMES - 1));

  // Frame counter: counts active frames, restarts on fire or pattern change.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= '0;
    end else if (pattern_chg_s || auto_fire_s) begin
      frame_cnt_r <= '0;
    end else if (counting_s) begin
      frame_cnt_r <= frame_cnt_r + FW'(1);
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end
`else
  assign auto_fire_s = 1'b0;
  logic unused_chg_s;
  assign unused_chg_s = pattern_chg_s;
`endif

  // State, pattern, request and status registers plus VSync sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= WAIT_VS;
      pattern_r   <= 2'd0;
      req_r       <= 1'b0;
      underflow_r <= 1'b0;
      vs_r        <= ~VS_POL;
      vs_d_r      <= ~VS_POL;
    end else begin
      state_r     <= state_n;
      pattern_r   <= pattern_n;
      req_r       <= req_n;
      underflow_r <= underflow_n;
      vs_r        <= vs;
      vs_d_r      <= vs_r;
    end
  end

  // Next-state, pending-request and pipeline-control decode.
  always_comb begin
    state_n       = state_r;
    pattern_n     = pattern_r;
    req_n         = req_r | press_s | auto_fire_s;
    underflow_n   = underflow_r;
    pattern_chg_s = 1'b0;
    gen_cke       = 1'b0;
    gen_rst       = 1'b1;
    fifo_flush    = 1'b1;
    case (state_r)
      WAIT_VS: begin
        if (vs_edge_s) begin
          // A press landing on the edge cycle is honoured immediately.
          if (req_r || press_s) begin
            pattern_n     = next_pattern(pattern_r, PAT_LAST);
            pattern_chg_s = 1'b1;
          end else begin
            pattern_n = pattern_r;
          end
          req_n   = 1'b0;
          state_n = PRIME;
        end else begin
          state_n = WAIT_VS;
        end
      end
      PRIME: begin
        gen_rst    = 1'b0;
        fifo_flush = 1'b0;
        // Enable drops combinationally the moment the FIFO reaches 3/4.
        gen_cke    = ~fifo_status[ST_HIGH];
        if (fifo_status[ST_HIGH]) begin
          state_n = RUN;
        end else begin
          state_n = PRIME;
        end
      end
      RUN: begin
        gen_rst    = 1'b0;
        fifo_flush = 1'b0;
        gen_cke    = ~fifo_status[ST_HIGH];
        if (!fifo_status[ST_NOT_EMPTY]) begin
          // Underflow wins; any pending request stays for the next edge.
          underflow_n = 1'b1;
          state_n     = WAIT_VS;
        end else if (req_r) begin
          state_n = WAIT_VS;
        end else begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = WAIT_VS;
      end
    endcase
  end

  assign pattern   = pattern_r;
  assign underflow = underflow_r;
  assign state     = state_r;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_ctrl
// Self-checking bench for vga_frame_ctrl (DEB_CYC=4, N_PAT=4, AUTO_FRAMES=3).
// Expected pattern values are queued when a change is provoked and popped by
// a monitor whenever the DUT pattern output changes.
// ---------------------------------------------------------------------------
module tb_vga_frame_ctrl;

  localparam int TB_DEB   = 4;
  localparam int TB_NPAT  = 4;

  logic       clk;
  logic       rst;
  logic       btn_n;
  logic       vs;
  logic [3:0] fifo_status;
  logic       gen_cke;
  logic       gen_rst;
  logic       fifo_flush;
  logic [1:0] pattern;
  logic       underflow;
  logic [1:0] state;

  int         n_checks;
  int         n_fail;
  logic [1:0] exp_q[$];
  logic [1:0] exp_pat;
  logic [1:0] mon_last;
  logic       mon_en;

  vga_frame_ctrl #(
    .DEB_CYC (TB_DEB),
    .N_PAT   (TB_NPAT),
    .VS_POL  (1'b0)
`ifdef VGA_FRAME_CTRL_AUTOCYCLE_EN
    ,
    .AUTO_FRAMES (3)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .vs          (vs),
    .fifo_status (fifo_status),
    .gen_cke     (gen_cke),
    .gen_rst     (gen_rst),
    .fifo_flush  (fifo_flush),
    .pattern     (pattern),
    .underflow   (underflow),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int budget, input string tag,
                            output int used);
    bit found;
    found = 1'b0;
    used  = budget;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      @(negedge clk);
      if (state == tgt) begin
        found = 1'b1;
        used  = i + 1;
      end
    end
    chk(tag, state, tgt);
  endtask

  // From PRIME: fill the FIFO to the high mark, enter RUN, then throttle open.
  task automatic to_run();
    fifo_status = 4'b1111;
    @(negedge clk);
    chk("prime_cke_drop", gen_cke, 1'b0);
    chk("prime_hold", state, 2'd1);
    tick();
    @(negedge clk);
    chk("run_state", state, 2'd2);
    fifo_status = 4'b0111;
    #1;
    chk("run_cke_open", gen_cke, 1'b1);
  endtask

  task automatic frame_to_prime(input string tag);
    int u;
    vs = 1'b0;
    wait_state(2'd1, 4, tag, u);
    vs = 1'b1;
    tick();
    tick();
  endtask

  task automatic hold_button(input int cycles);
    btn_n = 1'b0;
    repeat (cycles) tick();
    btn_n = 1'b1;
    repeat (TB_DEB + 4) tick();
  endtask

  // Press in RUN, expect fall back to WAIT_VS, then a frame edge advances.
  task automatic press_and_frame();
    int u;
    btn_n = 1'b0;
    wait_state(2'd0, TB_DEB + 4, "press_to_wait", u);
    repeat (10 - u) tick();
    btn_n = 1'b1;
    repeat (TB_DEB + 4) tick();
    exp_pat = (exp_pat == 2'(TB_NPAT - 1)) ? 2'd0 : exp_pat + 2'd1;
    exp_q.push_back(exp_pat);
    frame_to_prime("press_frame_prime");
    chk("press_pattern", pattern, exp_pat);
  endtask

  // Scoreboard monitor: each DUT pattern change must match the queue head.
  always @(negedge clk) begin
    if (mon_en && (pattern !== mon_last)) begin
      if (exp_q.size() == 0) begin
        chk("pat_unexpected", pattern, mon_last);
      end else begin
        chk("pat_seq", pattern, exp_q.pop_front());
      end
      mon_last = pattern;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout state=%0d", state);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    exp_pat     = 2'd0;
    mon_last    = 2'd0;
    mon_en      = 1'b0;
    rst         = 1'b1;
    btn_n       = 1'b1;
    vs          = 1'b1;
    fifo_status = 4'b0000;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_gen_cke", gen_cke, 1'b0);
    chk("rst_gen_rst", gen_rst, 1'b1);
    chk("rst_flush", fifo_flush, 1'b1);
    chk("rst_pattern", pattern, 2'd0);
    chk("rst_underflow", underflow, 1'b0);
    chk("rst_state", state, 2'd0);
    mon_en = 1'b1;
    rst    = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("idle_state", state, 2'd0);
    chk("idle_gen_rst", gen_rst, 1'b1);
    chk("idle_flush", fifo_flush, 1'b1);

    // First VSync leading edge: registered edge, then PRIME one cycle later.
    tick();
    vs = 1'b0;
    tick();
    @(negedge clk);
    chk("vs_edge_still_wait", state, 2'd0);
    chk("vs_edge_gen_rst", gen_rst, 1'b1);
    tick();
    @(negedge clk);
    chk("prime_state", state, 2'd1);
    chk("prime_cke", gen_cke, 1'b1);
    chk("prime_gen_rst", gen_rst, 1'b0);
    chk("prime_flush", fifo_flush, 1'b0);
    vs = 1'b1;
    tick();
    to_run();

    // Short glitch shorter than the debounce window is ignored.
    tick();
    btn_n = 1'b0;
    repeat (3) tick();
    btn_n = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    chk("glitch_ignored", state, 2'd2);
    chk("glitch_pattern", pattern, 2'd0);

    // Four accepted presses: 1, 2, 3, 0.
    for (int k = 0; k < 4; k++) begin
      tick();
      press_and_frame();
      tick();
      to_run();
    end

    // Two presses before a single edge advance the pattern once.
    tick();
    btn_n = 1'b0;
    begin
      int u;
      wait_state(2'd0, TB_DEB + 4, "dbl_press_wait", u);
      repeat (10 - u) tick();
    end
    btn_n = 1'b1;
    repeat (TB_DEB + 4) tick();
    hold_button(10);
    exp_pat = (exp_pat == 2'(TB_NPAT - 1)) ? 2'd0 : exp_pat + 2'd1;
    exp_q.push_back(exp_pat);
    frame_to_prime("dbl_prime");
    frame_to_prime("dbl_second_frame");
    chk("dbl_pattern_once", pattern, exp_pat);
    to_run();

    // Underflow: FIFO empties in RUN.
    tick();
    fifo_status = 4'b0000;
    tick();
    @(negedge clk);
    chk("uf_flag", underflow, 1'b1);
    chk("uf_state", state, 2'd0);
    tick();
    frame_to_prime("uf_recover_prime");
    to_run();
    @(negedge clk);
    chk("uf_sticky", underflow, 1'b1);

    // Reach pattern 2, then reset while in PRIME.
    tick();
    press_and_frame();
    chk("pre_rst_pattern", pattern, 2'd2);
    chk("pre_rst_prime", state, 2'd1);
    exp_pat = 2'd0;
    exp_q.push_back(exp_pat);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_pattern", pattern, 2'd0);
    chk("mid_rst_state", state, 2'd0);
    chk("mid_rst_gen_rst", gen_rst, 1'b1);
    chk("mid_rst_underflow", underflow, 1'b0);
    rst = 1'b0;
    tick();

    // Frames with no button activity: auto-cycle advances on frames 5 and 9.
    for (int f = 1; f <= 10; f++) begin
`ifdef VGA_FRAME_CTRL_AUTOCYCLE_EN
      if (f == 5 || f == 9) begin
        exp_pat = (exp_pat == 2'(TB_NPAT - 1)) ? 2'd0 : exp_pat + 2'd1;
        exp_q.push_back(exp_pat);
      end
`endif
      vs = 1'b0;
      tick();
      tick();
      vs = 1'b1;
      repeat (3) tick();
      if (state == 2'd1) begin
        to_run();
        tick();
      end
    end
    @(negedge clk);
    chk("frames_pattern", pattern, exp_pat);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
